// File: rtl/die_roller_pkg.sv
// Shared types and constants for the LFSR die roller.
// Covers FSM states, 7-segment glyphs and sides limits.
package die_roller_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLL,
    S_SHOW
  } state_e;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;

  localparam logic [3:0] SIDES_MIN    = 4'd2;
  localparam logic [3:0] SIDES_MAX    = 4'd9;
  localparam logic [3:0] REJECT_LIMIT = 4'd15;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    case (d)
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

  function automatic logic [3:0] clamp_sides(
    input logic [3:0] s
  );
    if (s < SIDES_MIN)
      clamp_sides = SIDES_MIN;
    else if (s > SIDES_MAX)
      clamp_sides = SIDES_MAX;
    else
      clamp_sides = s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer, debounce counter and press pulse.
// Level flips after DEBOUNCE_CYCLES differing synced samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/lfsr_die_roller.sv
// Animated N-sided die roll from an LFSR byte.
// Rejection sampling with a bounded retry keeps faces uniform.
module lfsr_die_roller
  import die_roller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ROLL_TICKS      = 8,
  parameter int TICK_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rnd_in,
  input  logic       roll_btn,
  input  logic [3:0] sides,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy,
  output logic [3:0] result,
  output logic       result_valid
);

  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(ROLL_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [3:0]    sides_q, sides_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    rej_q, rej_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    result_q, result_d;

  logic       press;
  logic       btn_level;
  logic       unused_ok;
  logic       fits;
  logic       accept;
  logic [3:0] face1;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (roll_btn),
    .level_o (btn_level),
    .press_o (press)
  );

  assign unused_ok = ^{rnd_in[7:4], btn_level};

  // Forced accept maps to face 0 once rejects hit the limit
  assign fits   = rnd_in[3:0] < sides_q;
  assign accept = fits || (rej_q == REJECT_LIMIT);
  assign face1  = (fits ? rnd_in[3:0] : 4'd0) + 4'd1;

  always_comb begin
    state_d  = state_q;
    sides_d  = sides_q;
    rem_d    = rem_q;
    tick_d   = tick_q;
    rej_d    = rej_q;
    seg_d    = seg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE, S_SHOW: begin
        if (press) begin
          state_d = S_ROLL;
          sides_d = clamp_sides(sides);
          rem_d   = RW'(ROLL_TICKS);
          tick_d  = '0;
          rej_d   = '0;
        end
      end
      S_ROLL: begin
        if (tick_q != TICK_LAST) begin
          tick_d = tick_q + 1'b1;
        end else if (accept) begin
          seg_d  = seg_of(face1);
          tick_d = '0;
          rej_d  = '0;
          rem_d  = rem_q - 1'b1;
          if (rem_q == RW'(1)) begin
            result_d = face1;
            state_d  = S_SHOW;
          end
        end else begin
          rej_d = rej_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sides_q  <= SIDES_MIN;
      rem_q    <= '0;
      tick_q   <= '0;
      rej_q    <= '0;
      seg_q    <= SEG_DASH;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sides_q  <= sides_d;
      rem_q    <= rem_d;
      tick_q   <= tick_d;
      rej_q    <= rej_d;
      seg_q    <= seg_d;
      result_q <= result_d;
    end
  end

  assign busy         = (state_q == S_ROLL);
  assign dp           = busy;
  assign result_valid = (state_q == S_SHOW);
  assign seg          = seg_q;
  assign result       = result_q;

endmodule

// File: tb/tb_lfsr_die_roller.sv
// Randomized bench for lfsr_die_roller.
// Rolls are predicted from the driven byte stream.
module tb_lfsr_die_roller;

  localparam int DEB   = 16;
  localparam int TICKS = 8;
  localparam int TDIV  = 4;
  localparam int MAXC  = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rnd_in;
  logic       roll_btn;
  logic [3:0] sides;
  logic [6:0] seg;
  logic       dp;
  logic       busy;
  logic [3:0] result;
  logic       result_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] arr [0:MAXC-1];
  logic [6:0] segtab [0:9] = '{
    7'h40, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  int         prev_result;
  logic [6:0] prev_seg;

  lfsr_die_roller #(
    .DEBOUNCE_CYCLES(DEB),
    .ROLL_TICKS     (TICKS),
    .TICK_DIV       (TDIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rnd_in       (rnd_in),
    .roll_btn     (roll_btn),
    .sides        (sides),
    .seg          (seg),
    .dp           (dp),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < MAXC; i++) arr[i] = v;
  endtask

  // Roll outcome from the byte stream: cycle 0 is the
  // first cycle with busy high.
  task automatic model_roll(
    input  logic [3:0] s,
    output int         len,
    output int         a1,
    output int         f1,
    output int         ff
  );
    int sc;
    int c;
    int tries;
    int face;
    sc = (s < 2) ? 2 : (s > 9) ? 9 : int'(s);
    c  = TDIV - 1;
    len = 0; a1 = 0; f1 = 0; ff = 0;
    for (int k = 0; k < TICKS; k++) begin
      tries = 0;
      while (int'(arr[c][3:0]) >= sc && tries < 15) begin
        tries++;
        c++;
      end
      face = (int'(arr[c][3:0]) < sc) ? int'(arr[c][3:0]) : 0;
      if (k == 0) begin
        a1 = c;
        f1 = face;
      end
      ff  = face;
      len = c + 1;
      c   = c + TDIV;
    end
  endtask

  task automatic do_roll(
    input  string      tag,
    input  logic [3:0] s,
    input  bit         rand_sides,
    input  bit         mid_press,
    output int         len_o,
    output int         res_o
  );
    int  n;
    int  exp_len, a1, f1, ff;
    bit  seen;
    len_o = 0;
    res_o = 0;
    n     = 0;
    seen  = 0;
    sides = s;
    model_roll(s, exp_len, a1, f1, ff);
    roll_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd_in = 8'($urandom);
      step();
      n = i + 1;
      if (busy) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_latency"},
        32'(seen && n >= 18 && n <= 20), 1);
    if (!seen) begin
      roll_btn = 1'b0;
      return;
    end
    chk({tag, "_rv_drop"}, 32'(result_valid), 0);
    chk({tag, "_res_hold"}, 32'(result), prev_result);
    chk({tag, "_seg_hold"}, 32'(seg), 32'(prev_seg));
    for (int c = 0; c < MAXC; c++) begin
      rnd_in = arr[c];
      if (rand_sides) sides = 4'($urandom);
      if (mid_press && c == 0)  roll_btn = 1'b0;
      if (mid_press && c == 40) roll_btn = 1'b1;
      step();
      if (c == a1)
        chk({tag, "_seg_first"}, 32'(seg),
            32'(segtab[f1 + 1]));
      if (!busy) begin
        len_o = c + 1;
        break;
      end
    end
    res_o = int'(result);
    chk({tag, "_busy_len"}, len_o, exp_len);
    chk({tag, "_result"}, 32'(result), ff + 1);
    chk({tag, "_seg"}, 32'(seg), 32'(segtab[ff + 1]));
    chk({tag, "_rv"}, 32'(result_valid), 1);
    chk({tag, "_dp"}, 32'(dp), 0);
    prev_result = ff + 1;
    prev_seg    = segtab[ff + 1];
    roll_btn = 1'b0;
    repeat (25) begin
      rnd_in = 8'($urandom);
      step();
    end
    chk({tag, "_show_hold"}, 32'(result_valid), 1);
  endtask

  initial begin
    int  len, res;
    bit  seen;
    bit  got;
    rst_n    = 1'b0;
    roll_btn = 1'($urandom);
    rnd_in   = 8'($urandom);
    sides    = 4'($urandom);
    step();
    step();
    chk("rst_seg", 32'(seg), 32'h40);
    chk("rst_dp", 32'(dp), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_rv", 32'(result_valid), 0);
    roll_btn    = 1'b0;
    rst_n       = 1'b1;
    prev_result = 0;
    prev_seg    = 7'h40;
    repeat (5) step();

    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 5 == 0) roll_btn = ~roll_btn;
      step();
      if (busy) seen = 1;
    end
    chk("bounce_no_busy", 32'(seen), 0);
    roll_btn = 1'b0;
    repeat (25) step();

    fill_const(8'h03);
    do_roll("clean", 4'd6, 0, 0, len, res);
    chk("clean_len32", len, 32);
    chk("clean_res4", res, 4);
    chk("clean_seg66", 32'(seg), 32'h66);

    fill_const(8'h0F);
    arr[8] = 8'h02;
    do_roll("retry", 4'd6, 0, 0, len, res);
    chk("retry_len", len, 9 + 7 * 19);

    fill_const(8'hFF);
    do_roll("bounded", 4'd6, 0, 0, len, res);
    chk("bounded_len152", len, 152);
    chk("bounded_res1", res, 1);
    chk("bounded_seg06", 32'(seg), 32'h06);

    fill_const(8'h08);
    do_roll("clamp", 4'd12, 0, 0, len, res);
    chk("clamp_res9", res, 9);
    chk("clamp_seg6f", 32'(seg), 32'h6F);

    fill_const(8'hFF);
    do_roll("ignore", 4'd12, 0, 1, len, res);
    chk("ignore_len152", len, 152);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < MAXC; i++) arr[i] = 8'($urandom);
      do_roll("rand", 4'($urandom), 1, 0, len, res);
    end

    sides    = 4'd6;
    roll_btn = 1'b1;
    got      = 0;
    for (int i = 0; i < 40; i++) begin
      rnd_in = 8'($urandom);
      step();
      if (busy) begin
        got = 1;
        break;
      end
    end
    chk("midrst_started", 32'(got), 1);
    repeat (10) begin
      rnd_in = 8'($urandom);
      step();
    end
    rst_n    = 1'b0;
    roll_btn = 1'b0;
    step();
    chk("midrst_seg", 32'(seg), 32'h40);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rv", 32'(result_valid), 0);
    chk("midrst_result", 32'(result), 0);
    rst_n       = 1'b1;
    prev_result = 0;
    prev_seg    = 7'h40;
    repeat (25) step();

    for (int i = 0; i < MAXC; i++) arr[i] = 8'($urandom);
    do_roll("post_rst", 4'($urandom), 1, 0, len, res);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_die_roller.md
# lfsr_die_roller

Consumes the free-running 8-bit pseudo-random byte from the LFSR stage and turns a debounced button press into an animated N-sided die roll shown on the 7-segment display. It sits between the LFSR output and the top-level display/IO pins. Rejection sampling keeps faces uniform, and a bounded retry rule prevents livelock.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synced samples required to change the debounced button level.
- `ROLL_TICKS`, default 8: accepted samples per roll, including the final result.
- `TICK_DIV`, default 4: cycles from tick start to first sample attempt.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `rnd_in` in 8: LFSR byte, new value every cycle; only `rnd_in[3:0]` is used.
- `roll_btn` in 1: raw, asynchronous, bouncy button.
- `sides` in 4: face count. Legal range is 2..9; 0–1 clamp to 2, 10–15 clamp to 9.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active high.
- `dp` out 1: decimal point; equals `busy`.
- `busy` out 1: high while in ROLL.
- `result` out 4: final face, 1..9.
- `result_valid` out 1: high while in SHOW.

## Operation
- Button path:
  - 2-flop synchronizer.
  - Debounced level flips only after the synced sample has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Press event is a 1-cycle pulse on a debounced 0→1 transition. Release generates no event.
- FSM states: IDLE, ROLL, SHOW.
  - IDLE/SHOW + press event → ROLL. On that edge, latch the clamped `sides` into `sides_q`, set `remaining = ROLL_TICKS`, clear the tick counter and the reject counter.
  - ROLL ignores press events and `sides` changes.
  - ROLL → SHOW on the edge that accepts a sample with `remaining == 1`.
  - SHOW holds until the next press event; there is no timeout.
- Sampling in ROLL:
  - Tick counter counts 0..TICK_DIV-1. A sample attempt occurs each cycle the counter equals TICK_DIV-1.
  - Accept when `rnd_in[3:0] < sides_q`; face = `rnd_in[3:0]`.
  - Reject otherwise. The counter holds at TICK_DIV-1, so the next cycle retries, and the reject counter increments.
  - Bounded retry: if the reject counter is 15 and the current attempt would reject, accept with face 0.
  - On accept:
    - `seg` ← encoding of face+1.
    - Tick counter and reject counter clear.
    - `remaining` decrements.
    - If this was the final accept, `result` ← face+1 and `result_valid` ← 1.
- Segment encodings:
  - 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Dash = 0x40.
- Reset values: `seg` = 0x40 (dash), `dp` = 0, `busy` = 0, `result` = 0, `result_valid` = 0. FSM in IDLE; all counters 0; debounced level 0.
- IDLE shows the dash. SHOW shows `result`.
- Entering ROLL from SHOW:
  - `result_valid` drops on the entry edge.
  - `result` holds its old value until the final accept.
  - `seg` keeps its last value until the first accept.

## Timing
- Press latency: a clean rising edge on `roll_btn` produces the press event 2 + `DEBOUNCE_CYCLES` cycles later (±1 for synchronizer phase). `busy` rises on the following edge.
- With no rejections:
  - Each tick lasts exactly `TICK_DIV` cycles.
  - `busy` stays high for `ROLL_TICKS*TICK_DIV` cycles.
  - `result_valid` rises in the same cycle `busy` falls.
- Each rejection adds 1 cycle to its tick. Worst-case tick length is `TICK_DIV + 15` cycles.
- `rst_n` low mid-ROLL: next edge returns to the reset values. Debounce state is lost, so a held button must be released and pressed again.
- A press event coincident with the final accept is ignored, because the FSM is still in ROLL.

## Structure
- Package `die_roller_pkg`: FSM state enum; 7-segment constants for digits 1..9 and the dash; `SIDES_MIN = 2`, `SIDES_MAX = 9`; `REJECT_LIMIT = 15`.
- Sub-module `btn_debounce`: synchronizer + debounce counter + rising-edge pulse. Parameter: `DEBOUNCE_CYCLES`. Ports: `clk`, `rst_n`, raw in, level out, press-pulse out.
- Top level: FSM, tick/reject/remaining counters, sides clamp, segment encoder.

## Test plan
All scenarios use the defaults (`DEBOUNCE_CYCLES` = 16, `TICK_DIV` = 4, `ROLL_TICKS` = 8).

1. Reset:
   - Stimulus: `rst_n` low 2 cycles with arbitrary inputs.
   - Required: `seg` = 0x40, `dp` = 0, `busy` = 0, `result` = 0, `result_valid` = 0.
2. Bounce rejection:
   - Stimulus: toggle `roll_btn` every 5 cycles for 200 cycles.
   - Required: `busy` never rises.
3. Clean roll:
   - Stimulus: `sides` = 6, `rnd_in` = 0x03 constant, one clean press.
   - Required: `busy` high exactly 32 cycles; then `result` = 4, `seg` = 0x66, `result_valid` = 1.
4. Rejection retry:
   - Stimulus: `sides` = 6, `rnd_in` = 0x0F except 0x02 on the cycle 5 cycles after the first sample attempt.
   - Required: first accept is delayed by 5 cycles, and the display shows 3 (0x4F).
5. Bounded retry:
   - Stimulus: `sides` = 6, `rnd_in` = 0xFF constant.
   - Required: each tick lasts 19 cycles, `busy` lasts 152 cycles, `result` = 1, `seg` = 0x06.
6. Clamp, ignore, restart:
   - Stimulus: `sides` = 12 and `rnd_in` = 0x08 give `result` = 9.
   - Required: a press during ROLL is ignored and does not extend `busy`.
   - Required: a press in SHOW restarts ROLL and drops `result_valid`.
   - Required: `rst_n` low mid-ROLL returns `seg` to 0x40.
